// File: rtl/dafx_amplitude_monitor.sv
// rtl/dafx_amplitude_monitor.sv - DAFX ADC/DAC signed min/max tracker with sticky clip interrupts
module dafx_amplitude_monitor #(
   parameter int AUDIO_WIDTH_C    = 24,
   parameter int CLIP_LEVEL_C     = 2**23 - 2**19,
   parameter int CLIP_CNT_WIDTH_C = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        adc_valid,
   input  logic [AUDIO_WIDTH_C-1:0]    adc_left,
   input  logic [AUDIO_WIDTH_C-1:0]    adc_right,
   input  logic                        dac_valid,
   input  logic [AUDIO_WIDTH_C-1:0]    dac_left,
   input  logic [AUDIO_WIDTH_C-1:0]    dac_right,
   input  logic                        cmd_clear_amplitude,
   input  logic                        cmd_clear_irq_0,
   input  logic                        cmd_clear_irq_1,
   output logic [AUDIO_WIDTH_C-1:0]    sr_cir_min_adc_amplitude,
   output logic [AUDIO_WIDTH_C-1:0]    sr_cir_max_adc_amplitude,
   output logic [AUDIO_WIDTH_C-1:0]    sr_cir_min_dac_amplitude,
   output logic [AUDIO_WIDTH_C-1:0]    sr_cir_max_dac_amplitude,
   output logic                        irq_0,
   output logic                        irq_1,
   output logic [CLIP_CNT_WIDTH_C-1:0] adc_clip_count,
   output logic [CLIP_CNT_WIDTH_C-1:0] dac_clip_count
);

   localparam int W = AUDIO_WIDTH_C;
   localparam int C = CLIP_CNT_WIDTH_C;

   // Threshold widened by one bit so it compares against the widened magnitude.
   localparam logic [W:0] CLIP_LEVEL_W = (W+1)'(CLIP_LEVEL_C);

   typedef enum logic {
      ST_EMPTY    = 1'b0,
      ST_TRACKING = 1'b1
   } track_state_t;

   function automatic logic [W-1:0] smin(input logic [W-1:0] a, input logic [W-1:0] b);
      return ($signed(a) < $signed(b)) ? a : b;
   endfunction

   function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // Magnitude is taken one bit wider so the most negative code yields 2**(W-1) and clips.
   function automatic logic is_clip(input logic [W-1:0] x);
      logic [W:0] ext;
      logic [W:0] mag;
      ext = {x[W-1], x};
      mag = ext[W] ? -ext : ext;
      return mag >= CLIP_LEVEL_W;
   endfunction

   // Index 0 is the ADC path, index 1 the DAC path.
   logic         path_valid [2];
   logic [W-1:0] path_left  [2];
   logic [W-1:0] path_right [2];
   logic         path_clr_irq [2];

   assign path_valid[0]   = adc_valid;
   assign path_left[0]    = adc_left;
   assign path_right[0]   = adc_right;
   assign path_clr_irq[0] = cmd_clear_irq_0;
   assign path_valid[1]   = dac_valid;
   assign path_left[1]    = dac_left;
   assign path_right[1]   = dac_right;
   assign path_clr_irq[1] = cmd_clear_irq_1;

   for (genvar p = 0; p < 2; p++) begin : path_g
      track_state_t state_q, state_d;
      logic [W-1:0] min_q, min_d;
      logic [W-1:0] max_q, max_d;
      logic         irq_q, irq_d;
      logic [C-1:0] cnt_q, cnt_d;

      // Next-state for min/max tracking; a clear forces EMPTY so a same-cycle sample starts afresh.
      always_comb begin
         track_state_t eff_state;
         logic [W-1:0] pair_min;
         logic [W-1:0] pair_max;
         state_d   = state_q;
         min_d     = min_q;
         max_d     = max_q;
         eff_state = state_q;
         pair_min  = smin(path_left[p], path_right[p]);
         pair_max  = smax(path_left[p], path_right[p]);
         if (cmd_clear_amplitude) begin
            state_d   = ST_EMPTY;
            eff_state = ST_EMPTY;
            min_d     = '0;
            max_d     = '0;
         end
         if (path_valid[p]) begin
            state_d = ST_TRACKING;
            if (eff_state == ST_EMPTY) begin
               min_d = pair_min;
               max_d = pair_max;
            end else begin
               min_d = smin(min_q, pair_min);
               max_d = smax(max_q, pair_max);
            end
         end
      end

      // Sticky clip interrupt and saturating counter; a clip in the clear cycle wins over the clear.
      always_comb begin
         irq_d = irq_q;
         cnt_d = cnt_q;
         if (path_clr_irq[p]) begin
            irq_d = 1'b0;
            cnt_d = '0;
         end
         if (path_valid[p] && (is_clip(path_left[p]) || is_clip(path_right[p]))) begin
            irq_d = 1'b1;
            if (cnt_d != {C{1'b1}}) begin
               cnt_d = cnt_d + C'(1);
            end
         end
      end

      // State register; reset drops any sample presented in the same cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            irq_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            irq_q   <= irq_d;
            cnt_q   <= cnt_d;
         end
      end
   end

   assign sr_cir_min_adc_amplitude = path_g[0].min_q;
   assign sr_cir_max_adc_amplitude = path_g[0].max_q;
   assign sr_cir_min_dac_amplitude = path_g[1].min_q;
   assign sr_cir_max_dac_amplitude = path_g[1].max_q;
   assign irq_0                    = path_g[0].irq_q;
   assign irq_1                    = path_g[1].irq_q;
   assign adc_clip_count           = path_g[0].cnt_q;
   assign dac_clip_count           = path_g[1].cnt_q;

endmodule
